// File: rtl/load_store_arbiter.sv
// load_store_arbiter
//   Arbitrates NUM_CH core channels onto a single DMA path. One channel is
//   granted at a time, round-robin from the channel after the last one granted.
//   A granted transfer sends one header beat on the write stream. A write then
//   streams the channel's write data, and a read then accepts read beats.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   core_req/rwn         per-channel request level and direction (1 = read)
//   core_hostAddr        NUM_CH x 40-bit host address, flattened
//   core_localAddr       NUM_CH x 14-bit local address, flattened
//   core_transferLength  NUM_CH x LEN_W beat count, flattened
//   core_writeData       NUM_CH x DATA_W write data, flattened
//   core_ready           one-hot, high while the channel owns the DMA path
//   core_ack             per-beat acknowledge to the active channel
//   core_readData        read data, broadcast to all channels
//   core_err             one-cycle timeout pulse to the active channel
//   dma_req/dma_resp     path request and grant
//   dma_write_*          header and write-data stream (valid/ready)
//   dma_read_*           read-data stream (valid/ready)
//   busy                 high whenever the FSM is not idle
//
// Configuration
//   LSC_TIMEOUT_EN : when defined, a wait of TIMEOUT_CYC cycles for dma_resp
//                    abandons the transfer and pulses core_err.

module load_store_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 128,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        core_req,
    input  logic [NUM_CH-1:0]        core_rwn,
    input  logic [NUM_CH*40-1:0]     core_hostAddr,
    input  logic [NUM_CH*14-1:0]     core_localAddr,
    input  logic [NUM_CH*LEN_W-1:0]  core_transferLength,
    input  logic [NUM_CH*DATA_W-1:0] core_writeData,
    output logic [NUM_CH-1:0]        core_ready,
    output logic [NUM_CH-1:0]        core_ack,
    output logic [DATA_W-1:0]        core_readData,
    output logic [NUM_CH-1:0]        core_err,
    output logic                     dma_req,
    input  logic                     dma_resp,
    output logic                     dma_write_valid,
    output logic [DATA_W-1:0]        dma_write_data,
    input  logic                     dma_write_ready,
    input  logic                     dma_read_valid,
    input  logic [DATA_W-1:0]        dma_read_data,
    output logic                     dma_read_ready,
    output logic                     busy
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Header layout: opcode(8) | length | hostAddr(40) | 2'b00 | localAddr(14)
    localparam int HDR_W = 64 + LEN_W;

    if (DATA_W < HDR_W) begin : g_chk_w
        $error("DATA_W too narrow for the header beat");
    end
    if (TIMEOUT_CYC < 1) begin : g_chk_t
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HDR   = 3'd2,
        WDATA = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CH_W-1:0]    last_q, last_d;
    logic               rwn_q, rwn_d;
    logic [39:0]        host_q, host_d;
    logic [13:0]        local_q, local_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
`ifdef LSC_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               tout_q, tout_d;
`endif

    logic               grant_vld;
    logic [CH_W-1:0]    pick;
    logic [NUM_CH-1:0]  ch_oh;
    logic [HDR_W-1:0]   hdr;

    assign ch_oh = NUM_CH'(1) << ch_q;
    assign hdr   = {(rwn_q ? 8'h01 : 8'h03), len_q, host_q, 2'b00, local_q};

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        logic [CH_W-1:0] cand;
        grant_vld = 1'b0;
        pick      = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((int'(last_q) + i) % NUM_CH);
            if (!grant_vld && core_req[cand]) begin
                grant_vld = 1'b1;
                pick      = cand;
            end
        end
    end

    // State register and latched transfer context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
            rwn_q   <= 1'b0;
            host_q  <= '0;
            local_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
`ifdef LSC_TIMEOUT_EN
            tmr_q   <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            rwn_q   <= rwn_d;
            host_q  <= host_d;
            local_q <= local_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifdef LSC_TIMEOUT_EN
            tmr_q   <= tmr_d;
            tout_q  <= tout_d;
`endif
        end
    end

    // Next-state and context update.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        last_d  = last_q;
        rwn_d   = rwn_q;
        host_d  = host_q;
        local_d = local_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
`ifdef LSC_TIMEOUT_EN
        tmr_d   = tmr_q;
        tout_d  = tout_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    ch_d    = pick;
                    rwn_d   = core_rwn[pick];
                    host_d  = core_hostAddr[pick*40 +: 40];
                    local_d = core_localAddr[pick*14 +: 14];
                    len_d   = core_transferLength[pick*LEN_W +: LEN_W];
                    cnt_d   = '0;
`ifdef LSC_TIMEOUT_EN
                    tmr_d   = '0;
                    tout_d  = 1'b0;
`endif
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dma_resp) begin
                    state_d = HDR;
                end
`ifdef LSC_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    tout_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
`endif
            end
            HDR: begin
                if (dma_write_ready) begin
                    if (len_q == '0) state_d = DONE;
                    else if (rwn_q)  state_d = RDATA;
                    else             state_d = WDATA;
                end
            end
            WDATA, RDATA: begin
                if ((state_q == WDATA) ? dma_write_ready : dma_read_valid) begin
                    // Compare before incrementing so an all-ones length never wraps.
                    if ((cnt_q + LEN_W'(1)) == len_q) state_d = DONE;
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            DONE: begin
                last_d  = ch_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from state so reset clears them on the same edge.
    always_comb begin
        busy            = (state_q != IDLE);
        dma_req         = (state_q == REQ);
        core_ready      = '0;
        core_ack        = '0;
        core_readData   = '0;
        dma_write_valid = 1'b0;
        dma_write_data  = '0;
        dma_read_ready  = 1'b0;
        case (state_q)
            HDR: begin
                core_ready                 = ch_oh;
                dma_write_valid            = 1'b1;
                dma_write_data[HDR_W-1:0]  = hdr;
            end
            WDATA: begin
                core_ready      = ch_oh;
                dma_write_valid = 1'b1;
                dma_write_data  = core_writeData[ch_q*DATA_W +: DATA_W];
                if (dma_write_ready) core_ack = ch_oh;
            end
            RDATA: begin
                core_ready     = ch_oh;
                dma_read_ready = 1'b1;
                core_readData  = dma_read_data;
                if (dma_read_valid) core_ack = ch_oh;
            end
            default: ;
        endcase
`ifdef LSC_TIMEOUT_EN
        core_err = (state_q == DONE && tout_q) ? ch_oh : '0;
`else
        core_err = '0;
`endif
    end

endmodule

// File: tb/tb_load_store_arbiter.sv
module tb_load_store_arbiter;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 128;
    localparam int LEN_W  = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        core_req;
    logic [NUM_CH-1:0]        core_rwn;
    logic [NUM_CH*40-1:0]     core_hostAddr;
    logic [NUM_CH*14-1:0]     core_localAddr;
    logic [NUM_CH*LEN_W-1:0]  core_transferLength;
    logic [NUM_CH*DATA_W-1:0] core_writeData;
    logic [NUM_CH-1:0]        core_ready;
    logic [NUM_CH-1:0]        core_ack;
    logic [DATA_W-1:0]        core_readData;
    logic [NUM_CH-1:0]        core_err;
    logic                     dma_req;
    logic                     dma_resp;
    logic                     dma_write_valid;
    logic [DATA_W-1:0]        dma_write_data;
    logic                     dma_write_ready;
    logic                     dma_read_valid;
    logic [DATA_W-1:0]        dma_read_data;
    logic                     dma_read_ready;
    logic                     busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    load_store_arbiter #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_rwn(core_rwn),
        .core_hostAddr(core_hostAddr), .core_localAddr(core_localAddr),
        .core_transferLength(core_transferLength), .core_writeData(core_writeData),
        .core_ready(core_ready), .core_ack(core_ack),
        .core_readData(core_readData), .core_err(core_err),
        .dma_req(dma_req), .dma_resp(dma_resp),
        .dma_write_valid(dma_write_valid), .dma_write_data(dma_write_data),
        .dma_write_ready(dma_write_ready),
        .dma_read_valid(dma_read_valid), .dma_read_data(dma_read_data),
        .dma_read_ready(dma_read_ready),
        .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic rwn, input logic [39:0] h,
                          input logic [13:0] l, input logic [15:0] len,
                          input logic [127:0] wd);
        core_rwn[c]                        = rwn;
        core_hostAddr[c*40 +: 40]          = h;
        core_localAddr[c*14 +: 14]         = l;
        core_transferLength[c*LEN_W +: LEN_W] = len;
        core_writeData[c*DATA_W +: DATA_W] = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_chk++;
        if ({busy, dma_req, dma_write_valid, dma_read_ready} !== 4'b0)
            $display("FAIL reset_ctrl got %b want 0000", {busy, dma_req, dma_write_valid, dma_read_ready});
        else n_pass++;
        n_chk++;
        if ({core_ready, core_ack, core_err} !== 12'b0)
            $display("FAIL reset_core got %h want 000", {core_ready, core_ack, core_err});
        else n_pass++;
        n_chk++;
        if ({dma_write_data, core_readData} !== '0)
            $display("FAIL reset_data got %h want 0", {dma_write_data, core_readData});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b0, 40'h0, 14'h0, 16'd0, '0);
        core_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int w = 0;
            while (core_ready === 4'b0 && w < 20) begin step(); w++; end
            exp = 4'b0001 << (k % 4);
            n_chk++;
            if (core_ready !== exp) $display("FAIL rr_grant%0d got %b want %b", k, core_ready, exp);
            else n_pass++;
            step();
        end
        core_req = '0;
        step();
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rr_idle got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_write();
        logic [127:0] exp_hdr;
        exp_hdr = {48'b0, 8'h03, 16'd3, 40'h12_3456_789A, 2'b00, 14'h0ABC};
        set_ch(1, 1'b0, 40'h12_3456_789A, 14'h0ABC, 16'd3, 128'hA0);
        core_req = 4'b0010;
        step();
        n_chk++;
        if ({dma_req, busy, core_ready} !== 6'b110000)
            $display("FAIL wr_req got %b want 110000", {dma_req, busy, core_ready});
        else n_pass++;
        step();
        core_req = '0;
        #1;
        n_chk++;
        if ({dma_write_valid, core_ready, core_ack} !== 9'b1_0010_0000)
            $display("FAIL wr_hdr_ctrl got %b want 100100000", {dma_write_valid, core_ready, core_ack});
        else n_pass++;
        n_chk++;
        if (dma_write_data !== exp_hdr) $display("FAIL wr_hdr got %h want %h", dma_write_data, exp_hdr);
        else n_pass++;
        for (int b = 0; b < 3; b++) begin
            step();
            core_writeData[DATA_W +: DATA_W] = 128'hB0 + 128'(b);
            #1;
            n_chk++;
            if (core_ack !== 4'b0010 || dma_write_data !== 128'hB0 + 128'(b))
                $display("FAIL wr_beat%0d got ack %b data %h want 0010 %h", b, core_ack, dma_write_data, 128'hB0 + 128'(b));
            else n_pass++;
        end
        step();
        n_chk++;
        if ({busy, core_ready, core_ack, dma_write_valid} !== 10'b1_0000_0000_0)
            $display("FAIL wr_done got %b want 1000000000", {busy, core_ready, core_ack, dma_write_valid});
        else n_pass++;
        step();
        n_chk++;
        if (busy !== 1'b0) $display("FAIL wr_idle got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_read_gapped();
        logic [127:0] exp_hdr;
        exp_hdr = {48'b0, 8'h01, 16'd2, 40'hFF_0000_0001, 2'b00, 14'h3FFF};
        set_ch(0, 1'b1, 40'hFF_0000_0001, 14'h3FFF, 16'd2, '0);
        core_req = 4'b0001;
        step();
        step();
        core_req = '0;
        #1;
        n_chk++;
        if (dma_write_data !== exp_hdr || dma_read_ready !== 1'b0)
            $display("FAIL rd_hdr got %h rr %b want %h rr 0", dma_write_data, dma_read_ready, exp_hdr);
        else n_pass++;
        step();
        n_chk++;
        if ({dma_read_ready, dma_write_valid, core_ack} !== 6'b10_0000)
            $display("FAIL rd_wait got %b want 100000", {dma_read_ready, dma_write_valid, core_ack});
        else n_pass++;
        dma_read_valid = 1'b1; dma_read_data = 128'hCAFE;
        #1;
        n_chk++;
        if (core_ack !== 4'b0001 || core_readData !== 128'hCAFE)
            $display("FAIL rd_beat0 got %b %h want 0001 cafe", core_ack, core_readData);
        else n_pass++;
        step();
        dma_read_valid = 1'b0;
        #1;
        n_chk++;
        if (core_ack !== 4'b0000 || dma_read_ready !== 1'b1)
            $display("FAIL rd_gap got %b %b want 0000 1", core_ack, dma_read_ready);
        else n_pass++;
        step();
        dma_read_valid = 1'b1; dma_read_data = 128'hBEEF;
        #1;
        n_chk++;
        if (core_ack !== 4'b0001 || core_readData !== 128'hBEEF)
            $display("FAIL rd_beat1 got %b %h want 0001 beef", core_ack, core_readData);
        else n_pass++;
        step();
        dma_read_valid = 1'b0;
        #1;
        n_chk++;
        if ({dma_read_ready, core_ack, core_ready} !== 9'b0)
            $display("FAIL rd_done got %b want 000000000", {dma_read_ready, core_ack, core_ready});
        else n_pass++;
        step();
    endtask

    task automatic test_zero_len();
        int acks = 0;
        int hdrs = 0;
        set_ch(3, 1'b0, 40'h55, 14'h11, 16'd0, 128'h77);
        core_req = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 1) core_req = '0;
            if (core_ack !== 4'b0) acks++;
            if (dma_write_valid && dma_write_ready) hdrs++;
        end
        n_chk++;
        if (acks !== 0 || hdrs !== 1) $display("FAIL zl_beats got acks %0d hdrs %0d want 0 1", acks, hdrs);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL zl_idle got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        set_ch(2, 1'b0, 40'h1, 14'h2, 16'd5, 128'h99);
        core_req = 4'b0100;
        step(); step();
        core_req = '0;
        step(); step();
        rst = 1'b1;
        step();
        n_chk++;
        if ({busy, dma_req, dma_write_valid, core_ready, core_ack} !== 11'b0 || dma_write_data !== '0)
            $display("FAIL rm_zero got %b %h want 0", {busy, dma_req, dma_write_valid, core_ready, core_ack}, dma_write_data);
        else n_pass++;
        rst = 1'b0;
        set_ch(1, 1'b0, 40'h3, 14'h4, 16'd1, 128'h31);
        set_ch(3, 1'b0, 40'h5, 14'h6, 16'd1, 128'h33);
        core_req = 4'b1010;
        step(); step();
        n_chk++;
        if (core_ready !== 4'b0010) $display("FAIL rm_grant got %b want 0010", core_ready);
        else n_pass++;
        core_req = '0;
        step();
        n_chk++;
        if (core_ack !== 4'b0010 || dma_write_data !== 128'h31)
            $display("FAIL rm_beat got %b %h want 0010 31", core_ack, dma_write_data);
        else n_pass++;
        step(); step();
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rm_idle got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int bad = 0;
        set_ch(2, 1'b0, 40'h8, 14'h9, 16'd0, '0);
        dma_resp = 1'b0;
        core_req = 4'b0100;
        step();
        core_req = '0;
`ifdef LSC_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            if (dma_req !== 1'b1 || core_err !== 4'b0) bad++;
            step();
        end
        if (dma_req !== 1'b1 || core_err !== 4'b0) bad++;
        n_chk++;
        if (bad != 0) $display("FAIL to_wait got %0d bad cycles want 0", bad);
        else n_pass++;
        step();
        n_chk++;
        if (core_err !== 4'b0100 || dma_req !== 1'b0)
            $display("FAIL to_err got %b %b want 0100 0", core_err, dma_req);
        else n_pass++;
        step();
        n_chk++;
        if (core_err !== 4'b0 || busy !== 1'b0) $display("FAIL to_end got %b %b want 0000 0", core_err, busy);
        else n_pass++;
        dma_resp = 1'b1;
`else
        for (int i = 0; i < 40; i++) begin
            if (dma_req !== 1'b1 || core_err !== 4'b0) bad++;
            step();
        end
        n_chk++;
        if (bad != 0) $display("FAIL nt_wait got %0d bad cycles want 0", bad);
        else n_pass++;
        dma_resp = 1'b1;
        step();
        n_chk++;
        if (core_ready !== 4'b0100) $display("FAIL nt_grant got %b want 0100", core_ready);
        else n_pass++;
        step(); step();
        n_chk++;
        if (busy !== 1'b0 || core_err !== 4'b0) $display("FAIL nt_idle got %b %b want 0 0000", busy, core_err);
        else n_pass++;
`endif
    endtask

    initial begin
        rst = 1'b1; core_req = '0; core_rwn = '0; core_hostAddr = '0; core_localAddr = '0;
        core_transferLength = '0; core_writeData = '0; dma_resp = 1'b1;
        dma_write_ready = 1'b1; dma_read_valid = 1'b0; dma_read_data = '0;
        test_reset();
        test_round_robin();
        test_write();
        test_read_gapped();
        test_zero_len();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
